// File: rtl/usr_shift_sequencer_if.sv
// Command (load-and-shift request) and response channels between a requester and the USR sequencer.
// USR_SEQ_ROTATE_EN adds the cmd_rot field to the command channel.
interface usr_shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
`ifdef USR_SEQ_ROTATE_EN
  logic             cmd_rot;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

`ifdef USR_SEQ_ROTATE_EN
  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill, cmd_rot, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill, cmd_rot, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
`else
  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/usr_shift_sequencer.sv
// Sequences one universal shift register: load, count shifts, capture; rsp_valid at count+3 after accept,
// commands held off (cmd_ready=0) until the response is taken. USR_SEQ_ROTATE_EN enables rotate mode.
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  usr_shift_sequencer_if.slave    req,
  output logic [1:0]              sr_select,
  output logic [WIDTH-1:0]        sr_parallel_in,
  output logic                    sr_shift_right,
  output logic                    sr_shift_left,
  input  logic [WIDTH-1:0]        sr_data_out,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic             lat_dir;
  logic             lat_fill;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             ser_bit;
  logic [1:0]       sel_nxt;
  logic             shr_nxt;
  logic             shl_nxt;
`ifdef USR_SEQ_ROTATE_EN
  logic             lat_rot;
`endif

  assign req.cmd_ready = (state == S_IDLE) & ~reset;
  assign accept        = req.cmd_valid & req.cmd_ready;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = SEL_HOLD;
    ser_bit   = lat_fill;
`ifdef USR_SEQ_ROTATE_EN
    // Serial bits are registered, so pick the bit that will be leaving when the shift lands:
    // the freshly loaded operand for the first shift, then one position in from the current edge.
    if (lat_rot) begin
      if (state == S_LOAD) begin
        ser_bit = lat_dir ? sr_parallel_in[WIDTH-1] : sr_parallel_in[0];
      end else begin
        ser_bit = lat_dir ? sr_data_out[WIDTH-2] : sr_data_out[1];
      end
    end
`endif
    case (state)
      S_IDLE:    if (accept) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = (cnt != '0) ? S_SHIFT : S_CAPTURE;
      S_SHIFT:   if (cnt == CNT_W'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_RESP;
      S_RESP:    if (req.rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_LOAD:  sel_nxt = SEL_LOAD;
      S_SHIFT: sel_nxt = lat_dir ? SEL_LEFT : SEL_RIGHT;
      default: sel_nxt = SEL_HOLD;
    endcase
    shr_nxt = (state_nxt == S_SHIFT) & ~lat_dir & ser_bit;
    shl_nxt = (state_nxt == S_SHIFT) &  lat_dir & ser_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_dir        <= 1'b0;
      lat_fill       <= 1'b0;
      cnt            <= '0;
      sr_select      <= SEL_HOLD;
      sr_parallel_in <= '0;
      sr_shift_right <= 1'b0;
      sr_shift_left  <= 1'b0;
      req.rsp_valid  <= 1'b0;
      req.rsp_data   <= '0;
`ifdef USR_SEQ_ROTATE_EN
      lat_rot        <= 1'b0;
`endif
    end else begin
      if (accept) begin
        lat_dir        <= req.cmd_dir;
        lat_fill       <= req.cmd_fill;
        cnt            <= req.cmd_count;
        sr_parallel_in <= req.cmd_data;
`ifdef USR_SEQ_ROTATE_EN
        lat_rot        <= req.cmd_rot;
`endif
      end else if (state == S_SHIFT) begin
        cnt <= cnt - 1'b1;
      end
      if (state == S_CAPTURE) begin
        req.rsp_data <= sr_data_out;
      end
      sr_select      <= sel_nxt;
      sr_shift_right <= shr_nxt;
      sr_shift_left  <= shl_nxt;
      req.rsp_valid  <= (state_nxt == S_RESP);
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer driving a behavioural 4-bit universal shift register.
module tb_usr_shift_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       sr_select;
  logic [WIDTH-1:0] sr_parallel_in;
  logic             sr_shift_right;
  logic             sr_shift_left;
  logic [WIDTH-1:0] sr_data_out;
  logic             busy;
  logic [WIDTH-1:0] usr_q = '0;

  int total = 0;
  int bad   = 0;

  usr_shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (bus),
    .sr_select      (sr_select),
    .sr_parallel_in (sr_parallel_in),
    .sr_shift_right (sr_shift_right),
    .sr_shift_left  (sr_shift_left),
    .sr_data_out    (sr_data_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Behavioural USR the sequencer controls.
  always @(posedge clk) begin
    case (sr_select)
      2'b01:   usr_q <= {sr_shift_right, usr_q[WIDTH-1:1]};
      2'b10:   usr_q <= {usr_q[WIDTH-2:0], sr_shift_left};
      2'b11:   usr_q <= sr_parallel_in;
      default: usr_q <= usr_q;
    endcase
  end
  assign sr_data_out = usr_q;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic             fill;
    logic             rot;
    int               hold;
    logic [WIDTH-1:0] exp_rsp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    bus.cmd_data  = v.data;
    bus.cmd_dir   = v.dir;
    bus.cmd_count = v.count;
    bus.cmd_fill  = v.fill;
`ifdef USR_SEQ_ROTATE_EN
    bus.cmd_rot   = v.rot;
`endif
  endtask

  task automatic scramble_cmd();
    bus.cmd_data  = WIDTH'($urandom);
    bus.cmd_dir   = 1'($urandom);
    bus.cmd_count = CNT_W'($urandom);
    bus.cmd_fill  = 1'($urandom);
`ifdef USR_SEQ_ROTATE_EN
    bus.cmd_rot   = 1'($urandom);
`endif
  endtask

  // Entered and left at a negedge with the sequencer idle.
  task automatic run_vec(input vec_t v);
    int cyc;
    logic [1:0] exp_sel;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    drive_cmd(v);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    scramble_cmd();
    cyc = 1;
    while (!bus.rsp_valid && cyc < 40) begin
      if (cyc == 1)                 exp_sel = 2'b11;
      else if (cyc <= v.count + 1)  exp_sel = v.dir ? 2'b10 : 2'b01;
      else                          exp_sel = 2'b00;
      chk("sr_select_seq", 32'(sr_select), 32'(exp_sel));
      chk("busy_in_flight", 32'(busy), 32'd1);
      chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk("rsp_latency", 32'(cyc), 32'(v.count) + 32'd3);
    chk("rsp_data", 32'(bus.rsp_data), 32'(v.exp_rsp));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_data_stable", 32'(bus.rsp_data), 32'(v.exp_rsp));
      chk("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
      chk("sr_select_resp", 32'(sr_select), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    //                 data     dir   cnt     fill  rot   hold  expected
    vecs.push_back('{4'b0110, 1'b0, 3'd1, 1'b1, 1'b0, 0, 4'b1011});
    vecs.push_back('{4'b0110, 1'b1, 3'd1, 1'b1, 1'b0, 0, 4'b1101});
    vecs.push_back('{4'b1100, 1'b0, 3'd3, 1'b0, 1'b0, 4, 4'b0001});
    vecs.push_back('{4'b1010, 1'b0, 3'd0, 1'b1, 1'b0, 1, 4'b1010});
    vecs.push_back('{4'b1001, 1'b1, 3'd2, 1'b0, 1'b0, 0, 4'b0100});
    vecs.push_back('{4'b0101, 1'b0, 3'd7, 1'b1, 1'b0, 0, 4'b1111});
    vecs.push_back('{4'b1111, 1'b1, 3'd4, 1'b0, 1'b0, 2, 4'b0000});
    vecs.push_back('{4'b0001, 1'b1, 3'd2, 1'b1, 1'b0, 0, 4'b0111});
    vecs.push_back('{4'b1000, 1'b0, 3'd2, 1'b0, 1'b0, 0, 4'b0010});
`ifdef USR_SEQ_ROTATE_EN
    vecs.push_back('{4'b1001, 1'b1, 3'd1, 1'b0, 1'b1, 0, 4'b0011});
    vecs.push_back('{4'b1001, 1'b0, 3'd2, 1'b0, 1'b1, 0, 4'b0110});
    vecs.push_back('{4'b0001, 1'b0, 3'd5, 1'b1, 1'b1, 0, 4'b1000});
`endif

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    scramble_cmd();
    @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_sr_select", 32'(sr_select), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);

    // A stray rsp_ready with no response pending must not disturb the next command.
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("stray_rsp_ready_idle", 32'(busy), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during SHIFT of a count=5 command abandons it and leaves the USR holding.
    begin
      vec_t v5;
      logic [WIDTH-1:0] held;
      v5 = '{4'b0110, 1'b0, 3'd5, 1'b1, 1'b0, 0, 4'b0000};
      drive_cmd(v5);
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("midrst_in_shift", 32'(sr_select), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_sr_select", 32'(sr_select), 32'd0);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      held  = usr_q;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_usr_holds", 32'(usr_q), 32'(held));
      chk("midrst_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    end

    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
